// File: rtl/block_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : block_mem_responder
// Description : Fixed-latency 128-bit line memory responder (one transaction
//               in flight). Optional read/write statistics under MEM_STAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module block_mem_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic           clk,
    input  logic           proc_reset,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic [31:4]    mem_addr,
    input  logic [127:0]   mem_wdata,
    output logic [127:0]   mem_rdata,
    output logic           mem_ready
`ifdef MEM_STAT_EN
    ,
    output logic [15:0]    stat_reads,
    output logic [15:0]    stat_writes
`endif
);

    localparam int         c_LINES    = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic                    r_is_write;
    logic [DEPTH_LOG2-1:0]   r_addr;
    logic [127:0]            r_wdata;
    logic [127:0]            r_mem [c_LINES];
    logic                    w_req;

    assign w_req = mem_read | mem_write;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_ready = 1'b0;
        mem_rdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_READY;
                end
            end
            S_READY: begin
                mem_ready = 1'b1;
                if (!r_is_write) begin
                    mem_rdata = r_mem[r_addr];
                end
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Write wins when both request lines are high at acceptance.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
        end else if (r_state == S_IDLE && w_req) begin
            r_cnt      <= c_CNT_INIT;
            r_is_write <= mem_write;
            r_addr     <= mem_addr[DEPTH_LOG2+3:4];
            r_wdata    <= mem_wdata;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!proc_reset && r_state == S_READY && r_is_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

`ifdef MEM_STAT_EN
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            stat_reads  <= 16'd0;
            stat_writes <= 16'd0;
        end else if (r_state == S_READY) begin
            if (r_is_write && stat_writes != 16'hFFFF) begin
                stat_writes <= stat_writes + 16'd1;
            end
            if (!r_is_write && stat_reads != 16'hFFFF) begin
                stat_reads <= stat_reads + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_mem_responder
// Description : Randomized scoreboard bench for block_mem_responder against a
//               line-array reference model (MEM_STAT_EN adds counter checks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_mem_responder;

    localparam int LATENCY    = 4;
    localparam int DEPTH_LOG2 = 8;
    localparam int LINES      = 1 << DEPTH_LOG2;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [31:4]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef MEM_STAT_EN
    logic [15:0]  stat_reads;
    logic [15:0]  stat_writes;
`endif

    block_mem_responder #(
        .LATENCY    (LATENCY),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef MEM_STAT_EN
        ,
        .stat_reads (stat_reads),
        .stat_writes(stat_writes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] model [LINES];
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;
    int           n_rd = 0;
    int           n_wr = 0;
    logic         prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor: every ready strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!proc_reset) begin
            if (mem_ready) begin
                check("single_pulse", 128'(prev_ready), 128'd0);
                if (sb.size() == 0) begin
                    check("unexpected_ready", 128'd1, 128'd0);
                end else begin
                    check("ready_latency", 128'(cyc + 1 - sb[0].acc), 128'(LATENCY));
                    check("rdata", mem_rdata, sb[0].data);
                    sb.pop_front();
                end
            end else begin
                check("rdata_idle_zero", mem_rdata, 128'd0);
            end
        end
        prev_ready <= mem_ready;
    end

    // Issue one transaction, then scramble addr/data while it is in flight.
    task automatic do_txn(input logic rd, input logic wr, input logic [27:0] addr,
                          input logic [127:0] data);
        int   k;
        int   line;
        exp_t e;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = data;
        @(posedge clk); #1;
        line   = int'(addr % LINES);
        e.acc  = cyc;
        if (wr) begin
            model[line] = data;
            e.data = 128'd0;
            n_wr++;
        end else begin
            e.data = model[line];
            n_rd++;
        end
        sb.push_back(e);
        mem_addr  = addr + 28'd1;
        mem_wdata = ~data;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            if (mem_ready) break;
            k++;
        end
        if (k == 50) check("ready_timeout", 128'd0, 128'd1);
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        logic [127:0] a5;
        proc_reset = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 128'(mem_ready), 128'd0);
        check("reset_rdata", mem_rdata, 128'd0);
        proc_reset = 1'b0;
        @(posedge clk); #1;

        // Fill every line, using random upper address bits to exercise wrap.
        for (int i = 0; i < LINES; i++) begin
            do_txn(1'b0, 1'b1, {20'($urandom()), 8'(i)}, rnd128());
        end

        a5 = {16{8'hA5}};
        do_txn(1'b0, 1'b1, 28'h0000010, a5);
        do_txn(1'b1, 1'b0, 28'h0000010, '0);
        do_txn(1'b0, 1'b1, 28'h0000100, 128'h1);
        do_txn(1'b1, 1'b0, 28'h0000000, '0);
        do_txn(1'b0, 1'b1, 28'h0000006, 128'h66);
        do_txn(1'b1, 1'b0, 28'h0000005, '0);
        do_txn(1'b1, 1'b1, 28'h0000020, 128'hF);
        do_txn(1'b1, 1'b0, 28'h0000020, '0);

        // Abort a write to line 7 with reset two cycles after acceptance.
        do_txn(1'b0, 1'b1, 28'h0000007, 128'h3);
        mem_write = 1'b1;
        mem_addr  = 28'h0000007;
        mem_wdata = 128'h99;
        @(posedge clk); #1;
        @(posedge clk); #1;
        proc_reset = 1'b1;
        mem_write  = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", 128'(mem_ready), 128'd0);
        proc_reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        do_txn(1'b1, 1'b0, 28'h0000007, '0);

        for (int i = 0; i < 300; i++) begin
            logic r, w;
            r = 1'($urandom());
            w = 1'($urandom());
            if (!r && !w) r = 1'b1;
            do_txn(r, w, 28'($urandom()), rnd128());
        end

        repeat (8) @(posedge clk);
        check("scoreboard_drain", 128'(sb.size()), 128'd0);
`ifdef MEM_STAT_EN
        #1;
        check("stat_reads", 128'(stat_reads), 128'(n_rd > 65535 ? 65535 : n_rd));
        check("stat_writes", 128'(stat_writes), 128'(n_wr > 65535 ? 65535 : n_wr));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_mem_responder.md
BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to mem_ready (legal range 2..15).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of the number of 128-bit lines stored.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port proc_reset, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have port mem_read, input, 1, line read request, held by the requester until mem_ready.
REQ-006 The block SHALL have port mem_write, input, 1, line write request, held by the requester until mem_ready.
REQ-007 The block SHALL have port mem_addr[31:4], input, 28, line address.
REQ-008 The block SHALL have port mem_wdata, input, 128, write line data.
REQ-009 The block SHALL have port mem_rdata, output, 128, read line data, valid only while mem_ready=1 for a read.
REQ-010 The block SHALL have port mem_ready, output, 1, one-cycle completion strobe.

Function
REQ-011 The FSM SHALL have states IDLE, WAIT, READY.
REQ-012 In IDLE, with mem_read or mem_write high, the block SHALL latch op, mem_addr[DEPTH_LOG2+3:4], and mem_wdata, then load the counter with LATENCY-2 and go to WAIT.
REQ-013 In WAIT, the counter SHALL decrement each cycle; at 0 the block SHALL go to READY.
REQ-014 In READY, mem_ready SHALL be 1 for exactly one cycle; mem_ready is 1 LATENCY cycles after the acceptance edge, then the block returns to IDLE.
REQ-015 A write SHALL update the array on the READY cycle edge, using only the latched data.
REQ-016 A read SHALL drive mem_rdata from the latched address during READY; outside READY, mem_rdata SHALL be 0.
REQ-017 Request inputs SHALL be ignored in WAIT and READY; changes to addr or data after acceptance have no effect.
REQ-018 Request high in the IDLE cycle after READY SHALL be accepted as a new transaction.
REQ-019 If mem_read and mem_write are both high at acceptance, the write SHALL be performed and the read ignored.
REQ-020 Address bits above DEPTH_LOG2+3 SHALL be ignored, so addresses wrap modulo 2^DEPTH_LOG2 lines.
REQ-021 A read following a write to the same line SHALL return the written data.

Reset
REQ-022 While proc_reset=1 at a clock edge, the block SHALL go to IDLE, set the counter to 0, mem_ready to 0 and mem_rdata to 0; any in-flight transaction is aborted with no array write.
REQ-023 Array contents SHALL NOT be cleared by reset and are undefined after power-up.

Configuration
REQ-024 When MEM_STAT_EN is defined, the block SHALL add outputs stat_reads[15:0] and stat_writes[15:0].
REQ-025 With MEM_STAT_EN defined:
- Each counter SHALL increment on every READY cycle of its op type.
- Each counter SHALL saturate at 16'hFFFF.
- Both counters SHALL reset to 0.
REQ-026 When MEM_STAT_EN is undefined, neither port nor counter logic SHALL exist, and all other behaviour is identical.

Verification (LATENCY=4, DEPTH_LOG2=8)
REQ-027 Write then read: write line 0x0000010 with data 128'hA5..A5, then read the same line -> mem_ready at cycle 4 after each acceptance; rdata=128'hA5..A5.
REQ-028 Wrap: write 0x0000100 with data 128'h1, then read 0x0000000 -> rdata=128'h1.
REQ-029 Mid-flight input change: accept a read of 0x5, change mem_addr to 0x6 at cycle 1 -> returns the line 0x5 data; exactly one mem_ready pulse.
REQ-030 Both mem_read and mem_write high, wdata=128'hF -> write performed; mem_rdata=0 on the ready cycle; a later read returns 128'hF.
REQ-031 proc_reset at cycle 2 of a write to 0x7 (old value 128'h3) -> no mem_ready; a later read of 0x7 returns 128'h3.
REQ-032 With MEM_STAT_EN defined: 3 reads and 2 writes -> stat_reads=3, stat_writes=2; after 70000 writes, stat_writes=16'hFFFF.
